// File: rtl/frame_sequencer.sv
// Frame sequencer: runs a tiny 6502-subset program from ROM and issues TIA register writes,
// stalling on stores to the WSYNC address until RDY returns.
module frame_sequencer #(
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned BANK_BITS   = 10,
  parameter logic [5:0]  WSYNC_ADDR  = 6'h02,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cyc_en,
  input  logic                   start,
  input  logic [ADDR_WIDTH:0]    rom_size,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [7:0]             rom_data,
  input  logic                   rdy,
  output logic [5:0]             tia_a,
  output logic [7:0]             tia_d,
  output logic                   tia_rw,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] cycle_count
);

  localparam int unsigned PC_W = ADDR_WIDTH + 1;
  localparam logic [PC_W:0] GRAN_ONE  = (PC_W+1)'(1) << BANK_BITS;
  localparam logic [PC_W:0] GRAN_MASK = GRAN_ONE - (PC_W+1)'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_WSYNC = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam logic [7:0] OP_LDA = 8'hA9;
  localparam logic [7:0] OP_LDX = 8'hA2;
  localparam logic [7:0] OP_LDY = 8'hA0;
  localparam logic [7:0] OP_NOP = 8'hEA;
  localparam logic [7:0] OP_STA = 8'h85;
  localparam logic [7:0] OP_STX = 8'h86;
  localparam logic [7:0] OP_STY = 8'h84;
  localparam logic [7:0] OP_JMP = 8'h4C;

  logic [2:0]             state, state_nxt;
  logic [PC_W-1:0]        pc, pc_nxt;
  logic [7:0]             op, op_nxt;
  logic [7:0]             reg_a, reg_a_nxt;
  logic [7:0]             reg_x, reg_x_nxt;
  logic [7:0]             reg_y, reg_y_nxt;
  logic [5:0]             tia_a_nxt;
  logic [7:0]             tia_d_nxt;
  logic                   tia_rw_nxt;
  logic                   busy_nxt, done_nxt, error_nxt;
  logic [COUNT_WIDTH-1:0] cc_nxt;
  logic                   do_fetch;

  logic [PC_W:0]   pc_inc_w, pc_jmp_w;
  logic [PC_W-1:0] pc_inc, pc_jmp;
  logic            is_short, is_long;
  logic [7:0]      store_src;

  assign rom_addr = pc[ADDR_WIDTH-1:0];

  // pc arithmetic saturates instead of wrapping so a runaway program always lands in DONE
  assign pc_inc_w = {1'b0, pc} + (PC_W+1)'(1);
  assign pc_inc   = pc_inc_w[PC_W] ? '1 : pc_inc_w[PC_W-1:0];
  assign pc_jmp_w = ({1'b0, pc} + GRAN_MASK) & ~GRAN_MASK;
  assign pc_jmp   = pc_jmp_w[PC_W] ? '1 : pc_jmp_w[PC_W-1:0];

  assign is_short = (rom_data == OP_LDA) || (rom_data == OP_LDX) ||
                    (rom_data == OP_LDY) || (rom_data == OP_NOP);
  assign is_long  = (rom_data == OP_STA) || (rom_data == OP_STX) ||
                    (rom_data == OP_STY) || (rom_data == OP_JMP);

  assign store_src = (op == OP_STA) ? reg_a : ((op == OP_STX) ? reg_x : reg_y);

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    op_nxt     = op;
    reg_a_nxt  = reg_a;
    reg_x_nxt  = reg_x;
    reg_y_nxt  = reg_y;
    tia_a_nxt  = tia_a;
    tia_d_nxt  = tia_d;
    tia_rw_nxt = 1'b1;
    done_nxt   = done;
    error_nxt  = error;
    cc_nxt     = (busy && !(&cycle_count)) ? cycle_count + COUNT_WIDTH'(1) : cycle_count;
    do_fetch   = 1'b0;

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          pc_nxt    = '0;
          cc_nxt    = '0;
          done_nxt  = 1'b0;
          error_nxt = 1'b0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: do_fetch = 1'b1;
      S_WAIT:  state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = S_FETCH;
        case (op)
          OP_LDA: begin reg_a_nxt = rom_data; pc_nxt = pc_inc; end
          OP_LDX: begin reg_x_nxt = rom_data; pc_nxt = pc_inc; end
          OP_LDY: begin reg_y_nxt = rom_data; pc_nxt = pc_inc; end
          OP_NOP: ;
          OP_JMP: pc_nxt = pc_jmp;
          OP_STA, OP_STX, OP_STY: begin
            tia_a_nxt  = rom_data[5:0];
            tia_d_nxt  = store_src;
            tia_rw_nxt = 1'b0;
            pc_nxt     = pc_inc;
            if (rom_data[5:0] == WSYNC_ADDR) state_nxt = S_WSYNC;
          end
          default: begin
            state_nxt = S_ERROR;
            error_nxt = 1'b1;
          end
        endcase
      end
      S_WSYNC: do_fetch = rdy;
      default: state_nxt = S_IDLE;
    endcase

    // Shared by FETCH and a released WSYNC stall
    if (do_fetch) begin
      if (pc >= rom_size) begin
        state_nxt = S_DONE;
        done_nxt  = 1'b1;
      end else begin
        op_nxt = rom_data;
        pc_nxt = pc_inc;
        if (is_short) begin
          state_nxt = S_EXEC;
        end else if (is_long) begin
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_ERROR;
          error_nxt = 1'b1;
        end
      end
    end

    busy_nxt = (state_nxt == S_FETCH) || (state_nxt == S_WAIT) ||
               (state_nxt == S_EXEC)  || (state_nxt == S_WSYNC);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      op          <= '0;
      reg_a       <= '0;
      reg_x       <= '0;
      reg_y       <= '0;
      tia_a       <= 6'h3F;
      tia_d       <= '0;
      tia_rw      <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cycle_count <= '0;
    end else if (cyc_en) begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      op          <= op_nxt;
      reg_a       <= reg_a_nxt;
      reg_x       <= reg_x_nxt;
      reg_y       <= reg_y_nxt;
      tia_a       <= tia_a_nxt;
      tia_d       <= tia_d_nxt;
      tia_rw      <= tia_rw_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      error       <= error_nxt;
      cycle_count <= cc_nxt;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: an instruction-level interpreter predicts, per enabled cycle,
// the bus write, pc, status flags and cycle count; random and directed programs are compared.
module tb_frame_sequencer;

  localparam int unsigned AW = 14;
  localparam int MAXC  = 8192;
  localparam int ROM_N = 1 << AW;
  localparam int GRAN  = 1024;

  logic        clock, reset, cyc_en, start, rdy;
  logic [AW:0] rom_size;
  logic [AW-1:0] rom_addr;
  logic [7:0]  rom_data;
  logic [5:0]  tia_a;
  logic [7:0]  tia_d;
  logic        tia_rw, busy, done, error;
  logic [31:0] cycle_count;

  logic [7:0] rom [0:ROM_N-1];
  assign rom_data = rom[rom_addr];

  frame_sequencer dut (
    .clock(clock), .reset(reset), .cyc_en(cyc_en), .start(start),
    .rom_size(rom_size), .rom_addr(rom_addr), .rom_data(rom_data), .rdy(rdy),
    .tia_a(tia_a), .tia_d(tia_d), .tia_rw(tia_rw), .busy(busy), .done(done),
    .error(error), .cycle_count(cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int en_period = 1;

  bit         rdy_tab [0:MAXC-1];
  int         exp_pc  [0:MAXC-1];
  bit         exp_wr  [0:MAXC-1];
  logic [5:0] exp_ta  [0:MAXC-1];
  logic [7:0] exp_td  [0:MAXC-1];
  int         exp_end;
  bit         exp_done;
  logic [7:0] m_a, m_x, m_y, m_td;
  logic [5:0] m_ta;

  function automatic bit legal(input logic [7:0] b);
    return b inside {8'hA9, 8'hA2, 8'hA0, 8'hEA, 8'h85, 8'h86, 8'h84, 8'h4C};
  endfunction

  task automatic note(input int c, input int p, input bit w);
    exp_pc[c] = p;
    exp_wr[c] = w;
    exp_ta[c] = m_ta;
    exp_td[c] = m_td;
  endtask

  // Instruction interpreter: each instruction costs 2 or 3 enabled cycles, WSYNC stores add
  // one cycle per following cycle with rdy low, the terminating fetch is the final cycle.
  task automatic model_run(input int size);
    int pc, cyc;
    logic [7:0] opc, opr;
    bit fin;
    pc = 0; cyc = 0; fin = 0; exp_done = 0;
    note(0, 0, 0);
    while (!fin && cyc < MAXC - 64) begin
      cyc++;
      if (pc >= size) begin
        note(cyc, pc, 0);
        exp_done = 1; fin = 1;
      end else begin
        opc = rom[pc % ROM_N]; pc++;
        note(cyc, pc, 0);
        if (opc == 8'hA9 || opc == 8'hA2 || opc == 8'hA0) begin
          cyc++; opr = rom[pc % ROM_N]; pc++;
          if (opc == 8'hA9) m_a = opr; else if (opc == 8'hA2) m_x = opr; else m_y = opr;
          note(cyc, pc, 0);
        end else if (opc == 8'hEA) begin
          cyc++; note(cyc, pc, 0);
        end else if (opc == 8'h85 || opc == 8'h86 || opc == 8'h84) begin
          cyc++; note(cyc, pc, 0);
          cyc++; opr = rom[pc % ROM_N]; pc++;
          m_ta = opr[5:0];
          m_td = (opc == 8'h85) ? m_a : ((opc == 8'h86) ? m_x : m_y);
          note(cyc, pc, 1);
          if (m_ta == 6'h02)
            while (cyc < MAXC - 64 && !rdy_tab[cyc+1]) begin cyc++; note(cyc, pc, 0); end
        end else if (opc == 8'h4C) begin
          cyc++; note(cyc, pc, 0);
          cyc++; pc = ((pc + GRAN - 1) / GRAN) * GRAN;
          note(cyc, pc, 0);
        end else begin
          fin = 1;
        end
      end
    end
    exp_end = cyc;
  endtask

  task automatic compare_cycle(input int n);
    int idx, e_cc;
    bit e_busy, e_rw, e_done, e_err;
    idx    = (n <= exp_end) ? n : exp_end;
    e_busy = (n < exp_end);
    e_cc   = idx;
    e_rw   = (n > exp_end) ? 1'b1 : !exp_wr[n];
    e_done = (n >= exp_end) && exp_done;
    e_err  = (n >= exp_end) && !exp_done;
    checks++;
    if (busy !== e_busy) begin errors++; $display("FAIL busy n=%0d got=%b want=%b", n, busy, e_busy); end
    checks++;
    if (cycle_count !== 32'(e_cc)) begin errors++; $display("FAIL cycle_count n=%0d got=%0d want=%0d", n, cycle_count, e_cc); end
    checks++;
    if (tia_rw !== e_rw) begin errors++; $display("FAIL tia_rw n=%0d got=%b want=%b", n, tia_rw, e_rw); end
    checks++;
    if (tia_a !== exp_ta[idx]) begin errors++; $display("FAIL tia_a n=%0d got=%h want=%h", n, tia_a, exp_ta[idx]); end
    checks++;
    if (tia_d !== exp_td[idx]) begin errors++; $display("FAIL tia_d n=%0d got=%h want=%h", n, tia_d, exp_td[idx]); end
    checks++;
    if (rom_addr !== AW'(exp_pc[idx])) begin errors++; $display("FAIL rom_addr n=%0d got=%h want=%h", n, rom_addr, AW'(exp_pc[idx])); end
    checks++;
    if (done !== e_done) begin errors++; $display("FAIL done n=%0d got=%b want=%b", n, done, e_done); end
    checks++;
    if (error !== e_err) begin errors++; $display("FAIL error n=%0d got=%b want=%b", n, error, e_err); end
  endtask

  // Idle clocks (cyc_en=0) must leave everything as after cycle n-1; then one enabled edge.
  task automatic step(input int n, input bit hold_check);
    for (int k = 1; k < en_period; k++) begin
      cyc_en = 1'b0;
      @(posedge clock); #1;
      if (hold_check) compare_cycle(n - 1);
    end
    cyc_en = 1'b1;
    @(posedge clock); #1;
    cyc_en = 1'b0;
    compare_cycle(n);
  endtask

  task automatic run_program(input int size, input bit noisy_start);
    rom_size = (AW+1)'(size);
    model_run(size);
    start = 1'b1; rdy = rdy_tab[0];
    step(0, 1'b0);
    for (int n = 1; n <= exp_end + 2; n++) begin
      start = (noisy_start && n <= exp_end) ? 1'($urandom_range(0, 1)) : 1'b0;
      rdy   = rdy_tab[n];
      step(n, 1'b1);
    end
    start = 1'b0;
  endtask

  task automatic set_rdy(input int pct_low);
    for (int i = 0; i < MAXC; i++) rdy_tab[i] = ($urandom_range(0, 99) >= pct_low);
  endtask

  task automatic model_reset();
    m_a = '0; m_x = '0; m_y = '0; m_ta = 6'h3F; m_td = '0;
  endtask

  task automatic load_basic();
    rom[0] = 8'hA9; rom[1] = 8'h55; rom[2] = 8'h85; rom[3] = 8'h09;
  endtask

  task automatic test_reset();
    reset = 1'b1; cyc_en = 1'b0; start = 1'b0; rdy = 1'b1; rom_size = '0;
    for (int i = 0; i < ROM_N; i++) rom[i] = 8'hFF;
    model_reset();
    #12;
    checks++; if (tia_a !== 6'h3F) begin errors++; $display("FAIL reset_tia_a got=%h want=3f", tia_a); end
    checks++; if (tia_d !== 8'h00) begin errors++; $display("FAIL reset_tia_d got=%h want=00", tia_d); end
    checks++; if (tia_rw !== 1'b1) begin errors++; $display("FAIL reset_tia_rw got=%b want=1", tia_rw); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b want=00", done, error); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", cycle_count); end
    checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_rom_addr got=%h want=0", rom_addr); end
    reset = 1'b0;
  endtask

  task automatic test_store_basic();
    load_basic(); set_rdy(0); en_period = 1;
    run_program(4, 1'b0);
    checks++; if (cycle_count !== 32'd6) begin errors++; $display("FAIL basic_count got=%0d want=6", cycle_count); end
    checks++; if (tia_a !== 6'h09 || tia_d !== 8'h55) begin errors++; $display("FAIL basic_write got=%h/%h want=09/55", tia_a, tia_d); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got=%b want=1", done); end
  endtask

  task automatic test_wsync();
    rom[0] = 8'hA2; rom[1] = 8'h11; rom[2] = 8'h86; rom[3] = 8'h02;
    rom[4] = 8'hA0; rom[5] = 8'h22; rom[6] = 8'h84; rom[7] = 8'h10;
    set_rdy(0);
    for (int i = 6; i <= 15; i++) rdy_tab[i] = 1'b0;
    run_program(8, 1'b0);
    checks++; if (tia_a !== 6'h10 || tia_d !== 8'h22) begin errors++; $display("FAIL wsync_write got=%h/%h want=10/22", tia_a, tia_d); end
    checks++; if (cycle_count !== 32'd21) begin errors++; $display("FAIL wsync_count got=%0d want=21", cycle_count); end
  endtask

  task automatic test_jmp();
    set_rdy(0);
    rom[0] = 8'hA9; rom[1] = 8'h01; rom[2] = 8'hA2; rom[3] = 8'h02; rom[4] = 8'hEA;
    rom[5] = 8'h4C; rom[6] = 8'h34; rom[7] = 8'h12; rom[16'h400] = 8'hEA;
    run_program(16'h401, 1'b0);
    checks++; if (rom_addr !== 14'h401 || done !== 1'b1) begin errors++; $display("FAIL jmp5 got=%h/%b want=401/1", rom_addr, done); end
    checks++; if (cycle_count !== 32'd12) begin errors++; $display("FAIL jmp5_count got=%0d want=12", cycle_count); end
    for (int i = 0; i < 16'h3FF; i++) rom[i] = 8'hEA;
    rom[16'h3FF] = 8'h4C;
    run_program(16'h401, 1'b0);
    checks++; if (rom_addr !== 14'h401 || done !== 1'b1) begin errors++; $display("FAIL jmp3ff got=%h/%b want=401/1", rom_addr, done); end
    checks++; if (cycle_count !== 32'd2052) begin errors++; $display("FAIL jmp3ff_count got=%0d want=2052", cycle_count); end
    rom[0] = 8'h4C;
    run_program(16'h200, 1'b0);
    checks++; if (rom_addr !== 14'h400 || done !== 1'b1 || cycle_count !== 32'd4) begin
      errors++; $display("FAIL jmp_past_end got=%h/%b/%0d want=400/1/4", rom_addr, done, cycle_count);
    end
  endtask

  task automatic test_error();
    rom[0] = 8'hA9; rom[1] = 8'h01; rom[2] = 8'hFF;
    set_rdy(0);
    run_program(3, 1'b0);
    checks++; if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL err_flags got=%b%b%b want=100", error, busy, done);
    end
    checks++; if (rom_addr !== 14'd3) begin errors++; $display("FAIL err_pc got=%h want=3", rom_addr); end
    run_program(3, 1'b0);
    checks++; if (error !== 1'b1 || cycle_count !== 32'd3) begin errors++; $display("FAIL err_restart got=%b/%0d want=1/3", error, cycle_count); end
  endtask

  task automatic test_cyc_en();
    int sz;
    en_period = 3;
    load_basic(); set_rdy(0);
    run_program(4, 1'b0);
    checks++; if (cycle_count !== 32'd6 || tia_a !== 6'h09 || tia_d !== 8'h55) begin
      errors++; $display("FAIL slow_basic got=%0d/%h/%h want=6/09/55", cycle_count, tia_a, tia_d);
    end
    set_rdy(40); gen_random(sz);
    run_program(sz, 1'b1);
    en_period = 1;
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    en_period = 1; load_basic(); rom_size = 15'd4; seen = 1'b0;
    start = 1'b1; cyc_en = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clock); #1;
      seen = (tia_rw === 1'b0);
    end
    cyc_en = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL midwrite_wait got=no_write want=write_within_20"); end
    #2; reset = 1'b1; #1;
    model_reset();
    checks++; if (tia_rw !== 1'b1 || tia_a !== 6'h3F || tia_d !== 8'h00) begin
      errors++; $display("FAIL midwrite_reset got=%b/%h/%h want=1/3f/00", tia_rw, tia_a, tia_d);
    end
    checks++; if (busy !== 1'b0 || cycle_count !== 32'd0 || rom_addr !== '0) begin
      errors++; $display("FAIL midwrite_state got=%b/%0d/%h want=0/0/0", busy, cycle_count, rom_addr);
    end
    @(posedge clock); #1;
    reset = 1'b0; cyc_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      checks++; if (busy !== 1'b0 || cycle_count !== 32'd0) begin
        errors++; $display("FAIL post_reset_idle got=%b/%0d want=0/0", busy, cycle_count);
      end
    end
    cyc_en = 1'b0;
    rom[0] = 8'h85; rom[1] = 8'h05;
    run_program(2, 1'b0);
    checks++; if (tia_a !== 6'h05 || tia_d !== 8'h00) begin errors++; $display("FAIL reset_reg_a got=%h/%h want=05/00", tia_a, tia_d); end
  endtask

  task automatic gen_random(output int size);
    int p, len, r;
    logic [7:0] b;
    for (int i = 0; i < 16'h480; i++) rom[i] = 8'($urandom);
    p = 0; len = 4 + $urandom_range(0, 36);
    while (p < len) begin
      r = $urandom_range(0, 19);
      if (r < 7) begin
        case (r % 3) 0: rom[p] = 8'hA9; 1: rom[p] = 8'hA2; default: rom[p] = 8'hA0; endcase
        rom[p+1] = 8'($urandom); p += 2;
      end else if (r < 16) begin
        case (r % 3) 0: rom[p] = 8'h85; 1: rom[p] = 8'h86; default: rom[p] = 8'h84; endcase
        b = 8'($urandom);
        if ($urandom_range(0, 2) == 0) b[5:0] = 6'h02;
        rom[p+1] = b; p += 2;
      end else if (r == 16) begin
        rom[p] = 8'h4C; p += 3;
      end else if (r == 17) begin
        b = 8'($urandom);
        if (legal(b)) b = 8'h02;
        rom[p] = b; p += 1;
      end else begin
        rom[p] = 8'hEA; p += 1;
      end
    end
    size = p - $urandom_range(0, 1);
  endtask

  task automatic test_random();
    int sz;
    for (int it = 0; it < 24; it++) begin
      set_rdy(30);
      en_period = $urandom_range(1, 3);
      gen_random(sz);
      run_program(sz, 1'b1);
    end
    en_period = 1;
  endtask

  initial begin
    test_reset();
    test_store_basic();
    test_wsync();
    test_jmp();
    test_error();
    test_cyc_en();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
